// File: rtl/mem_port_pkg.sv
// Shared types for the memory-side sequencer: FSM state encoding and
// word-alignment mask used to reject misaligned accesses.
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage : mem_port_pkg

// File: rtl/mem_port.sv
// Memory-side sequencer for the multicycle core. Converts the controller's
// single-cycle memory strobes into a req/gnt/rvalid bus transaction, freezes
// the controller with Stall until the access completes, and owns the
// instruction register and the load data register.
module mem_port
    import mem_port_pkg::*;
#(
    parameter  int AW = 32,
    localparam int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] Adr,
    input  logic [DW-1:0] WriteData,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic          IRWrite,
    output logic          Stall,
    output logic [DW-1:0] Instr,
    output logic [DW-1:0] ReadData,
    output logic          MemFault,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata
);

    mem_state_t state, state_nxt;
    logic       access;
    logic       aligned;
    logic       start;
    logic       dest_ir;

    // Classify the controller request presented this cycle.
    always_comb begin
        access  = MemRead | MemWrite;
        aligned = (Adr[1:0] & WORD_ALIGN_MASK) == 2'b00;
        start   = (state == IDLE) && access && aligned;
    end

    // Bus request comes only from registered state, never from the strobes.
    assign bus_req = (state == REQ);

    // State register.
    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // blocking assignments here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and Stall decode.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                    Stall     = 1'b1;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (bus_gnt) state_nxt = bus_we ? DONE : WAIT_R;
            end
            WAIT_R: begin
                Stall = 1'b1;
                if (bus_rvalid) state_nxt = DONE;
            end
            DONE: begin
                // Strobes still high here belong to the finished access.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset) Stall = 1'b0;
    end

    // Request latches: held stable from acceptance until the grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            dest_ir   <= 1'b0;
        end else if (start) begin
            bus_addr  <= Adr;
            bus_wdata <= WriteData;
            bus_we    <= MemWrite;   // read+write together is a write
            dest_ir   <= IRWrite;
        end
    end

    // Capture read data into the destination chosen at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr    <= '0;
            ReadData <= '0;
        end else if (state == WAIT_R && bus_rvalid) begin
            if (dest_ir) Instr    <= bus_rdata;
            else         ReadData <= bus_rdata;
        end
    end

    // Sticky misalignment flag; the offending access is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   MemFault <= 1'b0;
        else if (state == IDLE && access && !aligned) MemFault <= 1'b1;
    end

endmodule : mem_port

// File: tb/tb_mem_port.sv
// Directed testbench for mem_port: fetch, delayed-grant store, misaligned
// load, stray bus responses, reset mid-read and simultaneous strobes.
module tb_mem_port;

    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic [AW-1:0] Adr;
    logic [31:0]   WriteData;
    logic          MemWrite;
    logic          MemRead;
    logic          IRWrite;
    logic          Stall;
    logic [31:0]   Instr;
    logic [31:0]   ReadData;
    logic          MemFault;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_gnt;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .Adr        (Adr),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .IRWrite    (IRWrite),
        .Stall      (Stall),
        .Instr      (Instr),
        .ReadData   (ReadData),
        .MemFault   (MemFault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
    endtask

    initial begin
        reset     = 1'b0;
        Adr       = '0;
        WriteData = 32'h0;
        idle_inputs();

        // ---------------- reset state ----------------
        #12;
        check("rst_stall",    {63'd0, Stall},    64'd0);
        check("rst_req",      {63'd0, bus_req},  64'd0);
        check("rst_we",       {63'd0, bus_we},   64'd0);
        check("rst_fault",    {63'd0, MemFault}, 64'd0);
        check("rst_instr",    {32'd0, Instr},    64'd0);
        check("rst_rdata",    {32'd0, ReadData}, 64'd0);
        check("rst_addr",     {32'd0, bus_addr}, 64'd0);
        check("rst_wdata",    {32'd0, bus_wdata}, 64'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // ---------------- fetch ----------------
        // t0: IDLE with aligned fetch
        MemRead = 1'b1; IRWrite = 1'b1; Adr = 32'h100;
        sample();
        check("f_t0_stall", {63'd0, Stall},   64'd1);
        check("f_t0_req",   {63'd0, bus_req}, 64'd0);
        next_cycle();
        // t1: REQ, grant immediately
        bus_gnt = 1'b1;
        sample();
        check("f_t1_stall", {63'd0, Stall},    64'd1);
        check("f_t1_req",   {63'd0, bus_req},  64'd1);
        check("f_t1_addr",  {32'd0, bus_addr}, 64'h100);
        check("f_t1_we",    {63'd0, bus_we},   64'd0);
        next_cycle();
        // t2: WAIT_R, rvalid
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0050_0113;
        sample();
        check("f_t2_stall", {63'd0, Stall},   64'd1);
        check("f_t2_req",   {63'd0, bus_req}, 64'd0);
        next_cycle();
        // t3: DONE, strobes still high from the controller
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        sample();
        check("f_t3_stall", {63'd0, Stall},    64'd0);
        check("f_t3_instr", {32'd0, Instr},    64'h0050_0113);
        check("f_t3_rdata", {32'd0, ReadData}, 64'd0);
        next_cycle();
        // t4: controller advanced, strobes gone; no new access started in DONE
        idle_inputs();
        sample();
        check("f_t4_req",   {63'd0, bus_req}, 64'd0);
        check("f_t4_stall", {63'd0, Stall},   64'd0);
        next_cycle();

        // ---------------- store, grant delayed 3 cycles ----------------
        MemWrite = 1'b1; Adr = 32'h2004; WriteData = 32'hDEAD_BEEF;
        sample();
        check("s_t0_stall", {63'd0, Stall}, 64'd1);
        next_cycle();
        // Scramble the inputs: the request must come from the latches.
        Adr = 32'h3000; WriteData = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bus_gnt = (i == 3);
            sample();
            check($sformatf("s_req%0d_req",   i), {63'd0, bus_req},   64'd1);
            check($sformatf("s_req%0d_addr",  i), {32'd0, bus_addr},  64'h2004);
            check($sformatf("s_req%0d_wdata", i), {32'd0, bus_wdata}, 64'hDEAD_BEEF);
            check($sformatf("s_req%0d_we",    i), {63'd0, bus_we},    64'd1);
            check($sformatf("s_req%0d_stall", i), {63'd0, Stall},     64'd1);
            next_cycle();
        end
        bus_gnt = 1'b0;
        sample();
        check("s_done_stall", {63'd0, Stall},   64'd0);
        check("s_done_req",   {63'd0, bus_req}, 64'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // ---------------- misaligned load ----------------
        MemRead = 1'b1; Adr = 32'h103;
        sample();
        check("m_stall", {63'd0, Stall},   64'd0);
        check("m_req",   {63'd0, bus_req}, 64'd0);
        next_cycle();
        idle_inputs();
        sample();
        check("m_fault", {63'd0, MemFault}, 64'd1);
        check("m_req2",  {63'd0, bus_req},  64'd0);
        check("m_rdata", {32'd0, ReadData}, 64'd0);
        check("m_instr", {32'd0, Instr},    64'h0050_0113);
        next_cycle();

        // ---------------- stray responses around a good load ----------------
        // rvalid pulsed in IDLE with no access
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_0001;
        next_cycle();
        // t0: load accepted, stray rvalid again
        MemRead = 1'b1; Adr = 32'h400; bus_rdata = 32'hBAD0_0002;
        sample();
        check("r_t0_stall", {63'd0, Stall}, 64'd1);
        next_cycle();
        // REQ without grant, stray rvalid
        bus_rdata = 32'hBAD0_0003;
        sample();
        check("r_req0_req",   {63'd0, bus_req},  64'd1);
        check("r_req0_rdata", {32'd0, ReadData}, 64'd0);
        next_cycle();
        // REQ with grant
        bus_rvalid = 1'b0; bus_gnt = 1'b1;
        next_cycle();
        // WAIT_R, rvalid delayed one cycle
        bus_gnt = 1'b0;
        sample();
        check("r_w0_stall", {63'd0, Stall},    64'd1);
        check("r_w0_rdata", {32'd0, ReadData}, 64'd0);
        next_cycle();
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        sample();
        check("r_w1_stall", {63'd0, Stall}, 64'd1);
        next_cycle();
        bus_rvalid = 1'b0;
        sample();
        check("r_done_stall", {63'd0, Stall},    64'd0);
        check("r_done_rdata", {32'd0, ReadData}, 64'h1234_5678);
        check("r_done_instr", {32'd0, Instr},    64'h0050_0113);
        check("r_done_fault", {63'd0, MemFault}, 64'd1);
        next_cycle();
        idle_inputs();
        next_cycle();

        // ---------------- reset mid-read ----------------
        MemRead = 1'b1; IRWrite = 1'b1; Adr = 32'h180;
        next_cycle();
        bus_gnt = 1'b1;
        next_cycle();
        bus_gnt = 1'b0;
        sample();
        check("x_wait_stall", {63'd0, Stall}, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("x_req",   {63'd0, bus_req},  64'd0);
        check("x_stall", {63'd0, Stall},    64'd0);
        check("x_instr", {32'd0, Instr},    64'd0);
        check("x_rdata", {32'd0, ReadData}, 64'd0);
        check("x_fault", {63'd0, MemFault}, 64'd0);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        // late rvalid after release must be ignored
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_0004;
        next_cycle();
        bus_rvalid = 1'b0;
        sample();
        check("x_late_instr", {32'd0, Instr}, 64'd0);
        next_cycle();
        // fresh fetch
        MemRead = 1'b1; IRWrite = 1'b1; Adr = 32'h200;
        next_cycle();
        bus_gnt = 1'b1;
        next_cycle();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00A0_0093;
        next_cycle();
        bus_rvalid = 1'b0;
        sample();
        check("x2_instr", {32'd0, Instr}, 64'h00A0_0093);
        check("x2_stall", {63'd0, Stall}, 64'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // ---------------- simultaneous strobes ----------------
        MemRead = 1'b1; MemWrite = 1'b1; Adr = 32'h40; WriteData = 32'h0000_00AA;
        next_cycle();
        bus_gnt = 1'b1;
        sample();
        check("b_we",    {63'd0, bus_we},    64'd1);
        check("b_req",   {63'd0, bus_req},   64'd1);
        check("b_wdata", {32'd0, bus_wdata}, 64'hAA);
        next_cycle();
        bus_gnt = 1'b0;
        sample();
        check("b_done_stall", {63'd0, Stall},    64'd0);
        check("b_done_req",   {63'd0, bus_req},  64'd0);
        check("b_rdata",      {32'd0, ReadData}, 64'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_port

// File: doc/mem_port.md
# mem_port

Memory-side sequencer for the multicycle RISC-V core, directly downstream of the microcoded controller. It turns the controller's single-cycle memory strobes into a request/grant/response transaction on a variable-latency memory bus. It freezes the controller with `Stall` until the access completes. It also owns the instruction register (`Instr`) and the load data register (`ReadData`) that feed the controller and the datapath.

## Interface
- `AW`, default 32: bus/byte address width.
- `DW`, fixed 32: data width; not overridable.

Ports:
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `Adr`  in  AW  address from the address-source mux.
- `WriteData`  in  32  store data.
- `MemWrite`  in  1  store strobe from the controller.
- `MemRead`  in  1  load/fetch strobe from the controller.
- `IRWrite`  in  1  selects `Instr` as the read destination; otherwise `ReadData`.
- `Stall`  out  1  holds the controller micro-address and blocks all architectural writes.
- `Instr`  out  32  instruction register.
- `ReadData`  out  32  load data register.
- `MemFault`  out  1  sticky misalignment flag.
- `bus_req`  out  1  request valid.
- `bus_we`  out  1  request is a write.
- `bus_addr`  out  AW  request address.
- `bus_wdata`  out  32  write data.
- `bus_gnt`  in  1  request accepted.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, access pending (`MemRead|MemWrite`) with `Adr[1:0]==0`:
  - Latch `Adr`, `WriteData`, `bus_we=MemWrite` and the `IRWrite` destination.
  - Go to REQ.
- IDLE, access pending with `Adr[1:0]!=0`:
  - No bus transaction.
  - Set `MemFault`; it stays set until reset.
  - `Stall` stays 0, so the access is dropped.
  - `Instr` and `ReadData` are unchanged.
- `MemRead` and `MemWrite` asserted together: treat as a write.
- REQ:
  - `bus_req=1`; `bus_addr`, `bus_we` and `bus_wdata` stay stable from the latches until `bus_gnt`.
  - On grant of a write, go to DONE.
  - On grant of a read, go to WAIT_R.
- WAIT_R: on `bus_rvalid`, capture `bus_rdata` into the latched destination (`Instr` or `ReadData`), then go to DONE.
- DONE: `Stall=0` for one cycle so the controller advances, then return to IDLE unconditionally. The strobes still high in DONE belong to the completed access and never start a new one.
- `bus_rvalid` is ignored outside WAIT_R. `bus_gnt` is ignored outside REQ.
- `Stall` (combinational) is 1 in either case:
  - state IDLE with an aligned access pending;
  - state REQ or WAIT_R.
  - It is 0 otherwise and 0 whenever `reset==0`.
- `bus_req` is decoded from registered state only, with no combinational path from the controller strobes.

## Timing
- Reset values: state IDLE; `Instr`, `ReadData`, `bus_addr` and `bus_wdata` all 0; `bus_we`, `bus_req`, `MemFault` and `Stall` all 0.
- Asserting `reset` mid-transaction drops `bus_req` immediately and abandons the access. A later `bus_rvalid` is ignored.
- Read latency, with grant in the first REQ cycle and `rvalid` one cycle later:
  - Strobe seen in cycle t0 (IDLE).
  - REQ in t1, WAIT_R in t2, DONE in t3.
  - `Stall` is high in t0–t2.
  - The destination register is valid from t3.
  - The controller advances on the t3→t4 edge.
- Write latency, with grant in the first REQ cycle: `Stall` is high in t0–t1, DONE in t2.
- Each cycle of grant or rvalid delay adds exactly one `Stall` cycle.
- No back-to-back accesses: at least one DONE cycle separates transactions.

## Structure
- Shared package `mem_port_pkg` holds:
  - the FSM state enum `mem_state_t` (IDLE, REQ, WAIT_R, DONE);
  - `localparam WORD_ALIGN_MASK = 2'b11`.
- Single module; no sub-module is warranted.
- The controller needs a stall input that gates its `currAddr` update and qualifies PCWrite, RegWrite and IRWrite. That change is tracked separately.

## Test plan
- Fetch: `MemRead=1`, `IRWrite=1`, `Adr=0x100`, grant at t1, `rvalid` at t2 with `rdata=0x00500113`.
  - `Stall` is 1 for t0–t2.
  - `Instr=0x00500113` at t3.
  - `ReadData` is unchanged.
- Store: `MemWrite=1`, `Adr=0x2004`, `WriteData=0xDEADBEEF`, grant delayed 3 cycles.
  - `bus_req`, `bus_addr` and `bus_wdata` are stable for all 4 REQ cycles.
  - `Stall` is 1 for 5 cycles, then 0 in DONE.
- Misaligned load: `MemRead=1`, `Adr=0x103`.
  - `bus_req` stays 0 and `Stall` stays 0.
  - `MemFault=1` and stays set over later good accesses until reset.
- Stray bus responses: `bus_rvalid=1` pulsed in IDLE and in REQ has no effect. The read completes only on the `rvalid` seen in WAIT_R.
- Reset mid-read: `reset` driven to 0 while in WAIT_R.
  - `bus_req`, `Stall`, `Instr` and `ReadData` go to 0 immediately.
  - After release, a fresh fetch completes normally.
- Simultaneous strobes: `MemRead=1` and `MemWrite=1` produce `bus_we=1` and a write-length transaction.
